// File: rtl/mbist_pkg.sv
// March C- element table and FSM encodings shared by the controller and its compare stage.
// Pure constants: no latency, no backpressure.
package mbist_pkg;

  localparam int NUM_ELEM = 6;
  localparam int ELEM_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef enum logic [ELEM_W-1:0] {
    M0 = 3'd0,
    M1 = 3'd1,
    M2 = 3'd2,
    M3 = 3'd3,
    M4 = 3'd4,
    M5 = 3'd5
  } elem_e;

  // opN_bg is the background bit: written value for writes, expected value for reads
  typedef struct packed {
    logic two_ops;
    logic op0_we;
    logic op0_bg;
    logic op1_we;
    logic op1_bg;
    logic down;
  } elem_cfg_t;

  function automatic elem_cfg_t elem_cfg(input elem_e e);
    elem_cfg_t c;
    c = '0;
    case (e)
      M0: begin c.op0_we = 1'b1; end
      M1: begin c.two_ops = 1'b1; c.op1_we = 1'b1; c.op1_bg = 1'b1; end
      M2: begin c.two_ops = 1'b1; c.op0_bg = 1'b1; c.op1_we = 1'b1; end
      M3: begin c.two_ops = 1'b1; c.op1_we = 1'b1; c.op1_bg = 1'b1; c.down = 1'b1; end
      M4: begin c.two_ops = 1'b1; c.op0_bg = 1'b1; c.op1_we = 1'b1; c.down = 1'b1; end
      M5: begin c.op0_bg = 1'b0; end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mbist_march_ctrl_if.sv
// SRAM-under-test port bundle: controller drives select/command/address/data, memory returns read data.
// Read data is valid one cycle after a read; no backpressure.
interface mbist_march_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);

  logic              mem_cs;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_cs,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_cs,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mbist_cmp.sv
// Read-compare stage: registers expected word per read, compares next cycle, sticky fail + first-fail capture.
// fail visible two cycles after the read is issued; no backpressure.
module mbist_cmp
  import mbist_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              rd_vld,
  input  logic [DATA_W-1:0] rd_exp,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [ELEM_W-1:0] rd_elem,
  input  logic [DATA_W-1:0] rdata,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [ELEM_W-1:0] fail_elem
);

  logic              vld_q;
  logic [DATA_W-1:0] exp_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ELEM_W-1:0] elem_q;

  logic              fail_q,  fail_d;
  logic [ADDR_W-1:0] faddr_q, faddr_d;
  logic [ELEM_W-1:0] felem_q, felem_d;

  logic miscmp;

  assign miscmp = vld_q && (rdata != exp_q);

  always_comb begin
    fail_d  = fail_q;
    faddr_d = faddr_q;
    felem_d = felem_q;
    if (clr) begin
      fail_d  = 1'b0;
      faddr_d = '0;
      felem_d = '0;
    end else if (miscmp) begin
      fail_d = 1'b1;
      // only the first miscompare of a run is captured
      if (!fail_q) begin
        faddr_d = addr_q;
        felem_d = elem_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= 1'b0;
      exp_q   <= '0;
      addr_q  <= '0;
      elem_q  <= '0;
      fail_q  <= 1'b0;
      faddr_q <= '0;
      felem_q <= '0;
    end else begin
      vld_q   <= rd_vld;
      exp_q   <= rd_exp;
      addr_q  <= rd_addr;
      elem_q  <= rd_elem;
      fail_q  <= fail_d;
      faddr_q <= faddr_d;
      felem_q <= felem_d;
    end
  end

  assign fail      = fail_q;
  assign fail_addr = faddr_q;
  assign fail_elem = felem_q;

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- sequencer: first op one cycle after start, 10N RUN cycles, 1 DRAIN cycle, then DONE.
// No backpressure: the SRAM must accept one operation every RUN cycle.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic [ADDR_W-1:0]  fail_addr,
  output logic [ELEM_W-1:0]  fail_elem,
  output logic               cnt_en,
  output logic               cnt_ud,
  output logic               cnt_rst,
  input  logic [ADDR_W-1:0]  cnt_q,
  mbist_march_ctrl_if.master mem
);

  state_e state_q, state_d;
  elem_e  elem_q,  elem_d;
  logic   op_q,    op_d;

  elem_cfg_t         cfg;
  logic              cur_we;
  logic              cur_bg;
  logic              last_op;
  logic              elem_end;
  logic              clr;
  logic              rd_vld;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] bg_word;

  assign cfg      = elem_cfg(elem_q);
  assign cur_we   = op_q ? cfg.op1_we : cfg.op0_we;
  assign cur_bg   = op_q ? cfg.op1_bg : cfg.op0_bg;
  assign last_op  = ~cfg.two_ops | op_q;
  assign elem_end = last_op && (cnt_q == {ADDR_W{1'b1}});
  // descending elements reuse the up-counter by inverting its value
  assign op_addr  = cfg.down ? ~cnt_q : cnt_q;
  assign bg_word  = {DATA_W{cur_bg}};
  assign cnt_ud   = 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      elem_q  <= M0;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    elem_d        = elem_q;
    op_d          = op_q;
    clr           = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    cnt_en        = 1'b0;
    cnt_rst       = 1'b0;
    rd_vld        = 1'b0;
    mem.mem_cs    = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        cnt_rst = 1'b1;
        done    = (state_q == ST_DONE);
        if (start) begin
          state_d = ST_RUN;
          elem_d  = M0;
          op_d    = 1'b0;
          clr     = 1'b1;
        end
      end
      ST_RUN: begin
        busy          = 1'b1;
        mem.mem_cs    = 1'b1;
        mem.mem_we    = cur_we;
        mem.mem_addr  = op_addr;
        mem.mem_wdata = cur_we ? bg_word : '0;
        rd_vld        = ~cur_we;
        cnt_en        = last_op;
        op_d          = ~last_op;
        if (elem_end) begin
          cnt_rst = 1'b1;
          op_d    = 1'b0;
          if (elem_q == M5) begin
            state_d = ST_DRAIN;
          end else begin
            elem_d = elem_e'(elem_q + 3'd1);
          end
        end
      end
      ST_DRAIN: begin
        busy    = 1'b1;
        cnt_rst = 1'b1;
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  mbist_cmp #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_cmp (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .rd_vld   (rd_vld),
    .rd_exp   (bg_word),
    .rd_addr  (op_addr),
    .rd_elem  (elem_q),
    .rdata    (mem.mem_rdata),
    .fail     (fail),
    .fail_addr(fail_addr),
    .fail_elem(fail_elem)
  );

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: faulty SRAM model, up-counter, March C- reference model and op/result scoreboard.
module tb_mbist_march_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, fail;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;
  logic          cnt_en, cnt_ud, cnt_rst;
  logic [AW-1:0] cnt_q;

  always #5 clk = ~clk;

  mbist_march_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

  mbist_march_ctrl #(.ADDR_W(AW), .DATA_W(DW)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .fail     (fail),
    .fail_addr(fail_addr),
    .fail_elem(fail_elem),
    .cnt_en   (cnt_en),
    .cnt_ud   (cnt_ud),
    .cnt_rst  (cnt_rst),
    .cnt_q    (cnt_q),
    .mem      (mif.master)
  );

  // Address counter, two bits longer than the address so it never wraps in range
  logic [AW+1:0] cnt;
  assign cnt_q = cnt[AW-1:0];
  always @(posedge clk) begin
    if (rst || cnt_rst) cnt <= '0;
    else if (cnt_en)    cnt <= cnt_ud ? cnt + (AW+2)'(1) : cnt - (AW+2)'(1);
  end

  // Fault kinds: 0 none, 1 stuck-at-0, 2 stuck-at-1, 3 bit cannot go 1->0
  int f_kind [2];
  int f_addr [2];
  int f_bit  [2];

  function automatic logic [DW-1:0] fault_write(input int a, input logic [DW-1:0] old, input logic [DW-1:0] nw);
    logic [DW-1:0] v;
    v = nw;
    for (int i = 0; i < 2; i++) begin
      if (f_kind[i] != 0 && f_addr[i] == a) begin
        case (f_kind[i])
          1: v[f_bit[i]] = 1'b0;
          2: v[f_bit[i]] = 1'b1;
          3: if (old[f_bit[i]] && !nw[f_bit[i]]) v[f_bit[i]] = 1'b1;
          default: ;
        endcase
      end
    end
    return v;
  endfunction

  logic [DW-1:0] mem [N];
  logic [DW-1:0] img [N];
  logic          load_img = 1'b0;

  always @(posedge clk) begin
    if (load_img) begin
      for (int i = 0; i < N; i++) mem[i] <= img[i];
    end else if (mif.mem_cs) begin
      if (mif.mem_we)
        mem[mif.mem_addr] <= fault_write(int'(mif.mem_addr), mem[mif.mem_addr], mif.mem_wdata);
      else
        mif.mem_rdata <= mem[mif.mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
  } op_t;

  typedef struct packed {
    int            done_cyc;
    logic          fail;
    logic [AW-1:0] addr;
    logic [2:0]    elem;
  } res_t;

  op_t  exp_ops [$];
  res_t exp_res [$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic flag_fail(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event seen, required none (cycle %0d)", nm, cyc);
  endtask

  // March C- as written: element direction and op list; op codes 0=r0 1=r1 2=w0 3=w1
  int e_nops [6]    = '{1, 2, 2, 2, 2, 1};
  bit e_down [6]    = '{0, 0, 0, 1, 1, 0};
  int e_op   [6][2] = '{'{2, 0}, '{0, 3}, '{1, 2}, '{0, 3}, '{1, 2}, '{0, 0}};

  task automatic build_expect(input int start_cyc);
    logic [DW-1:0] m [N];
    res_t          r;
    op_t           o;
    int            a;
    int            code;
    logic [DW-1:0] d;
    for (int i = 0; i < N; i++) m[i] = img[i];
    r.done_cyc = start_cyc + 10 * N + 2;
    r.fail     = 1'b0;
    r.addr     = '0;
    r.elem     = '0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        a = e_down[e] ? (N - 1 - i) : i;
        for (int k = 0; k < e_nops[e]; k++) begin
          code   = e_op[e][k];
          d      = (code % 2 == 1) ? {DW{1'b1}} : {DW{1'b0}};
          o.we   = (code >= 2);
          o.addr = AW'(a);
          o.dat  = d;
          exp_ops.push_back(o);
          if (o.we) begin
            m[a] = fault_write(a, m[a], d);
          end else if (m[a] !== d && !r.fail) begin
            r.fail = 1'b1;
            r.addr = AW'(a);
            r.elem = 3'(e);
          end
        end
      end
    end
    exp_res.push_back(r);
  endtask

  // Monitor: pops expected ops on every memory access and the expected result when done rises
  initial begin : monitor
    bit   done_prev;
    int   ops_seen;
    op_t  o;
    res_t r;
    done_prev = 1'b0;
    ops_seen  = 0;
    forever begin
      @(negedge clk);
      if (mif.mem_cs) begin
        ops_seen++;
        if (exp_ops.size() == 0) begin
          flag_fail("extra_mem_op");
        end else begin
          o = exp_ops.pop_front();
          chk("op_we", 64'(mif.mem_we), 64'(o.we));
          chk("op_addr", 64'(mif.mem_addr), 64'(o.addr));
          if (o.we) chk("op_wdata", 64'(mif.mem_wdata), 64'(o.dat));
        end
      end
      if (done && !done_prev) begin
        if (exp_res.size() == 0) begin
          flag_fail("unexpected_done");
        end else begin
          r = exp_res.pop_front();
          chk("done_cycle", 64'(cyc), 64'(r.done_cyc));
          chk("fail", 64'(fail), 64'(r.fail));
          chk("fail_addr", 64'(fail_addr), 64'(r.addr));
          chk("fail_elem", 64'(fail_elem), 64'(r.elem));
          chk("op_count", 64'(ops_seen), 64'(10 * N));
          chk("busy_in_done", 64'(busy), 64'd0);
          chk("cnt_no_wrap", 64'(cnt[AW+1:AW]), 64'd0);
        end
        ops_seen = 0;
      end
      done_prev = done;
      if (rst) begin
        exp_ops.delete();
        exp_res.delete();
        ops_seen  = 0;
        done_prev = 1'b0;
      end
    end
  end

  task automatic begin_run(output int sc);
    load_img = 1'b1;
    @(posedge clk); #1;
    load_img = 1'b0;
    sc = cyc;
    build_expect(sc);
    start = 1'b1;
  endtask

  task automatic do_run(input bit hold);
    int sc;
    bit seen;
    begin_run(sc);
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    chk("fail_cleared_on_start", 64'(fail), 64'd0);
    chk("busy_after_start", 64'(busy), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 12 * N && !seen; i++) begin
      @(posedge clk); #1;
      if (hold && cyc >= sc + 10 * N + 1) start = 1'b0;
      seen = done;
    end
    start = 1'b0;
    if (!seen) flag_fail("done_timeout");
    @(negedge clk); #1;
  endtask

  task automatic clear_faults();
    for (int i = 0; i < 2; i++) begin
      f_kind[i] = 0;
      f_addr[i] = 0;
      f_bit[i]  = 0;
    end
  endtask

  initial begin : stim
    int sc;
    clear_faults();
    for (int i = 0; i < N; i++) img[i] = '0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_fail", 64'(fail), 64'd0);
    chk("rst_cnt_en", 64'(cnt_en), 64'd0);
    chk("rst_cnt_rst", 64'(cnt_rst), 64'd1);
    chk("rst_cnt_ud", 64'(cnt_ud), 64'd1);
    chk("rst_mem_cs", 64'(mif.mem_cs), 64'd0);
    chk("rst_mem_we", 64'(mif.mem_we), 64'd0);
    chk("rst_fail_addr", 64'(fail_addr), 64'd0);
    chk("rst_fail_elem", 64'(fail_elem), 64'd0);
    chk("rst_mem_addr", 64'(mif.mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mif.mem_wdata), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_run(1'b0);

    f_kind[0] = 2; f_addr[0] = 5; f_bit[0] = 0;
    do_run(1'b0);

    clear_faults();
    f_kind[0] = 3; f_addr[0] = 9; f_bit[0] = 3;
    do_run(1'b0);

    clear_faults();
    f_kind[0] = 2; f_addr[0] = 2;  f_bit[0] = 1;
    f_kind[1] = 2; f_addr[1] = 12; f_bit[1] = 6;
    do_run(1'b0);

    // Reset in the middle of M2 after M1 has already flagged a miscompare
    clear_faults();
    f_kind[0] = 2; f_addr[0] = 5; f_bit[0] = 0;
    begin_run(sc);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3 * N + 7) @(posedge clk);
    #1;
    chk("fail_before_rst", 64'(fail), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_mem_cs", 64'(mif.mem_cs), 64'd0);
    chk("rst_mid_cnt_rst", 64'(cnt_rst), 64'd1);
    chk("rst_mid_fail", 64'(fail), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    clear_faults();
    do_run(1'b0);

    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < N; i++) img[i] = DW'($urandom);
      f_kind[0] = int'($urandom_range(0, 3));
      f_addr[0] = int'($urandom_range(0, N - 1));
      f_bit[0]  = int'($urandom_range(0, DW - 1));
      f_kind[1] = (r % 2 == 1) ? int'($urandom_range(1, 3)) : 0;
      f_addr[1] = int'($urandom_range(0, N - 1));
      f_bit[1]  = int'($urandom_range(0, DW - 1));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      do_run(1'b0);
    end

    // A faulty run followed by a fault-free rerun from DONE with start held through RUN
    clear_faults();
    for (int i = 0; i < N; i++) img[i] = '0;
    f_kind[0] = 1; f_addr[0] = 7; f_bit[0] = 4;
    do_run(1'b0);
    clear_faults();
    do_run(1'b1);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(exp_ops.size() + exp_res.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mbist_march_ctrl.md
# mbist_march_ctrl

March C- sequencing controller for the MBIST datapath. Drives the address counter (`counter`) through its enable/direction/reset inputs and consumes its count value to generate every memory read and write. Compares read data against the expected background and reports pass/fail with first-failure capture. Sits between the BIST start/status interface and the SRAM under test.

## Interface
- `ADDR_W`, 10: memory address width; depth N = 2^ADDR_W.
- `DATA_W`, 8: memory word width.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin test; sampled only in IDLE or DONE.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  high in DONE.
- `fail`  out  1  sticky miscompare flag; valid when `done`=1.
- `fail_addr`  out  ADDR_W  address of first miscompare.
- `fail_elem`  out  3  March element index (0-5) of first miscompare.
- `cnt_en`  out  1  counter advance.
- `cnt_ud`  out  1  counter direction; tied 1.
- `cnt_rst`  out  1  counter clear.
- `cnt_q`  in  ADDR_W  counter value; low ADDR_W bits of the counter, whose length is ADDR_W+2 so its stop never fires in range.
- `mem_cs`  out  1  memory select.
- `mem_we`  out  1  1 = write, 0 = read.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  write data.
- `mem_rdata`  in  DATA_W  read data, valid one cycle after a read.

## Operation
- Elements:
  - M0 ⇑(w0)
  - M1 ⇑(r0,w1)
  - M2 ⇑(r1,w0)
  - M3 ⇓(r0,w1)
  - M4 ⇓(r1,w0)
  - M5 ⇑(r0)
- Background: "0" = all-zeros, "1" = all-ones across DATA_W.
- Registered state:
  - top FSM: IDLE, RUN, DRAIN, DONE
  - `elem` (0-5)
  - `op` (0-1)
- Counter always counts up. `mem_addr` = `~cnt_q` in M3/M4, otherwise `cnt_q`. The ⇓ order is therefore N-1 down to 0 with no counter preload.
- RUN: one memory operation per cycle.
  - `mem_cs`=1.
  - `mem_we`/`mem_wdata` are decoded from (`elem`,`op`).
  - `cnt_en`=1 only on the last op of the element at the current address.
- Element end: last op and `cnt_q`==N-1.
  - Assert `cnt_rst` (it overrides `cnt_en` in the counter) and advance `elem`; reset `op`.
  - At the end of M5, go to DRAIN.
- DRAIN (1 cycle): `mem_cs`=0; performs the final compare, then moves to DONE.
- Compare:
  - Every read registers an expected word, a compare-valid bit, address and element.
  - Next cycle: if valid and `mem_rdata`≠expected, set `fail`.
  - On the first such event only, load `fail_addr`/`fail_elem`.
- IDLE/DONE:
  - `mem_cs`=0, `cnt_rst`=1, `cnt_en`=0.
  - `start`=1 moves to RUN and clears `fail`, `fail_addr`, `fail_elem`, `elem`, `op`.
- `start` is ignored in RUN/DRAIN.
- `rst` in any state: next edge is IDLE, and all registers return to reset values. An in-flight compare is discarded.

## Timing
- Reset values:
  - `busy`, `done`, `fail`, `cnt_en`, `mem_cs`, `mem_we` = 0
  - `fail_addr`, `fail_elem`, `mem_addr`, `mem_wdata` = 0
  - `cnt_rst`=1
  - `cnt_ud`=1
- `start` sampled at edge k: first operation (M0 w0 at address 0) is presented in cycle k+1.
- RUN lasts exactly 10N cycles. DRAIN is cycle k+10N+1. `done`=1 from cycle k+10N+2 and holds until `start` or `rst`.
- Read in cycle t: compare uses `mem_rdata` in t+1. `fail` is visible from t+2.
- Element boundary: the counter clears on the same edge that advances `elem`. No idle cycle between elements.
- Address wrap: `cnt_q`=N-1 is always an element end. The counter is never allowed to wrap.

## Structure
- Package `mbist_pkg` holds:
  - state enum (IDLE/RUN/DRAIN/DONE)
  - element indices M0..M5
  - per-element constants: op count, op0/op1 type and data, direction
- Sub-module `mbist_cmp` holds the expected-data pipeline register, sticky `fail`, and first-fail capture. `mbist_march_ctrl` instantiates it.
- `counter` is instantiated by the parent and wired to the `cnt_*` ports.

## Test plan
- Fault-free SRAM model, ADDR_W=4, DATA_W=8, `start` at cycle 0:
  - `done` rises at cycle 162, `fail`=0.
  - Exactly 160 memory operations.
  - M3's first address is 15.
- Stuck-at-1 on bit 0 at address 5 → `fail`=1, `fail_addr`=5, `fail_elem`=1.
- Transition fault (bit 3 at address 9 cannot go 1→0) → `fail_addr`=9, `fail_elem`=3. Later M5 miscompares do not overwrite the capture.
- Two faults (address 2 in M1, address 12 in M1) → `fail_addr`=2 (first captured only).
- `rst` pulsed mid-M2:
  - next cycle `busy`=0, `mem_cs`=0, `cnt_rst`=1, `fail`=0.
  - re-`start` on a fault-free model → `done` after 10N+2 cycles.
- `start` held high during RUN → no restart, same completion cycle. From DONE, `start` reruns the test with `fail` cleared.
